// File: rtl/seq_call_pkg.sv
// seq_call_pkg: opcodes, state encodings and instruction field offsets for seq_call
package seq_call_pkg;
  localparam logic [3:0] SEQ_NO = 4'd0, SEQ_CI = 4'd1, SEQ_CR = 4'd2, SEQ_JI = 4'd3, SEQ_JR = 4'd4;
  localparam logic [3:0] SEQ_JZ = 4'd5, SEQ_CALL = 4'd6, SEQ_RET = 4'd7, SEQ_WT = 4'd8;
  localparam logic [1:0] ST_RESET = 2'd0, ST_READY = 2'd1, ST_ERROR = 2'd2;
  function automatic int addr_lo(int data_w);
    return data_w;
  endfunction
  function automatic int cmd_lo(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction
  function automatic int dev_lo(int cmd_w, int addr_w, int data_w);
    return cmd_w + addr_w + data_w;
  endfunction
  function automatic int code_lo(int dev_w, int cmd_w, int addr_w, int data_w);
    return dev_w + cmd_w + addr_w + data_w;
  endfunction
endpackage

// File: rtl/seq_call_stack.sv
// seq_call_stack: return-address LIFO with synchronous clear, push/pop ignored when full/empty
module seq_call_stack #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int SP_W = $clog2(DEPTH + 1);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [SP_W-1:0] sp;
  logic [W-1:0] mem [DEPTH];
  assign full = sp == SP_W'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[IDX_W'(sp - 1'b1)];
  always_ff @(posedge clock)
    if (clear) sp <= '0;
    else if (push && !full) begin
      mem[IDX_W'(sp)] <= din;
      sp <= sp + 1'b1;
    end else if (pop && !empty) sp <= sp - 1'b1;
endmodule

// File: rtl/seq_call.sv
// seq_call: program sequencer with call/return stack; opcode WT only when SEQ_CALL_WAIT_EN is defined
module seq_call
  import seq_call_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CMD_W = 4,
  parameter int DEV_W = 3,
  parameter int NUM_IREG = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3+DEV_W+CMD_W+ADDR_W+DATA_W:0] inst,
  input  logic                           inst_en,
  input  logic [NUM_IREG*DATA_W-1:0]     ireg,
  output logic [ADDR_W-1:0]              next,
  output logic [CMD_W+DATA_W-1:0]        oreg,
  output logic [2**DEV_W-1:0]            oreg_wen,
  output logic                           error
);
  localparam int SRC_W = NUM_IREG > 1 ? $clog2(NUM_IREG) : 1;
  localparam int NUM_DEV = 2 ** DEV_W;
  localparam int A_LO = addr_lo(DATA_W);
  localparam int C_LO = cmd_lo(ADDR_W, DATA_W);
  localparam int D_LO = dev_lo(CMD_W, ADDR_W, DATA_W);
  localparam int O_LO = code_lo(DEV_W, CMD_W, ADDR_W, DATA_W);
  logic [1:0] state, nx_state;
  logic [3:0] code;
  logic [DEV_W-1:0] dev;
  logic [CMD_W-1:0] cmd;
  logic [ADDR_W-1:0] addr, inc, top, nx_next;
  logic [DATA_W-1:0] arg, sel;
  logic [SRC_W-1:0] src;
  logic [CMD_W+DATA_W-1:0] nx_oreg;
  logic [NUM_DEV-1:0] nx_wen;
  logic push, pop, full, empty, bad;
  assign code = inst[O_LO +: 4];
  assign dev = inst[D_LO +: DEV_W];
  assign cmd = inst[C_LO +: CMD_W];
  assign addr = inst[A_LO +: ADDR_W];
  assign arg = inst[DATA_W-1:0];
  assign src = arg[SRC_W-1:0];
  assign inc = next + 1'b1;
  assign error = state == ST_ERROR;
  seq_call_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clock(clock), .clear(reset), .push(push), .pop(pop), .din(inc), .dout(top), .full(full), .empty(empty)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IREG; i++) if (src == SRC_W'(i)) sel = ireg[i*DATA_W +: DATA_W];
  end
  always_comb begin
    nx_state = state;
    nx_next = next;
    nx_oreg = '0;
    nx_wen = '0;
    push = 1'b0;
    pop = 1'b0;
    bad = 1'b0;
    case (state)
      ST_RESET: begin
        nx_state = ST_READY;
        nx_next = '0;
      end
      ST_READY:
        if (inst_en)
          case (code)
            SEQ_NO: nx_next = inc;
            SEQ_CI: begin
              nx_next = inc;
              nx_oreg = {cmd, arg};
              nx_wen = NUM_DEV'(1) << dev;
            end
            SEQ_CR: begin
              nx_next = inc;
              nx_oreg = {cmd, sel};
              nx_wen = NUM_DEV'(1) << dev;
            end
            SEQ_JI: nx_next = addr;
            SEQ_JR: nx_next = ADDR_W'(sel);
            SEQ_JZ: nx_next = sel == '0 ? addr : inc;
            SEQ_CALL: begin
              push = !full;
              bad = full;
              nx_next = addr;
            end
            SEQ_RET: begin
              pop = !empty;
              bad = empty;
              nx_next = top;
            end
`ifdef SEQ_CALL_WAIT_EN
            SEQ_WT: nx_next = sel == '0 ? next : inc;
`else
            SEQ_WT: bad = 1'b1;
`endif
            default: bad = 1'b1;
          endcase
      default: bad = 1'b1;
    endcase
    if (bad) begin
      nx_state = ST_ERROR;
      nx_next = '0;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_RESET;
      next <= '0;
      oreg <= '0;
      oreg_wen <= '0;
    end else begin
      state <= nx_state;
      next <= nx_next;
      oreg <= nx_oreg;
      oreg_wen <= nx_wen;
    end
endmodule
